// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand forwarding, load-use and multicycle RAW interlocks with a BUSY watchdog.
// Define HAZARD_SCOREBOARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 200,
  parameter int MC_CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic              PCSrc_E,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [1:0]        ResultSrc_E,
  input  logic              mc_start_E,
  input  logic              mc_op_D,
  input  logic              mc_done,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              FlushD,
  output logic              mc_busy,
  output logic              mc_timeout,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [REG_AW-1:0]   REG_ZERO     = '0;
  localparam logic [MC_CNT_W-1:0] TIMEOUT_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

  state_e              state_q;
  logic [REG_AW-1:0]   pend_rd_q;
  logic [MC_CNT_W-1:0] busy_cnt_q;
  logic                timeout_q;

  logic busy;
  logic lwStall;
  logic mcStall;
  logic hazard;

  function automatic logic [1:0] fwd_sel(
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w,
    input logic [REG_AW-1:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // The counter holds the number of completed BUSY cycles, so the trip fires at the end of
  // the MC_TIMEOUT-th BUSY cycle and the stall drops on the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_start_E) begin
            state_q    <= BUSY;
            pend_rd_q  <= Rd_E;
            busy_cnt_q <= '0;
          end
        end
        BUSY: begin
          busy_cnt_q <= busy_cnt_q + 1'b1;
          if (mc_done) begin
            state_q <= IDLE;
          end else if (busy_cnt_q == TIMEOUT_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == BUSY);
  assign lwStall = (ResultSrc_E == 2'b01) && (Rd_E != REG_ZERO) &&
                   ((RS1_D == Rd_E) || (RS2_D == Rd_E));
  assign mcStall = (mc_start_E && (Rd_E != REG_ZERO) && ((RS1_D == Rd_E) || (RS2_D == Rd_E))) ||
                   (busy && (pend_rd_q != REG_ZERO) &&
                    ((RS1_D == pend_rd_q) || (RS2_D == pend_rd_q))) ||
                   ((busy || mc_start_E) && mc_op_D);
  assign hazard  = lwStall || mcStall;

  // A taken branch squashes the younger instructions, so it overrides any pending stall.
  always_comb begin
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushE     = 1'b0;
    FlushD     = 1'b0;
    mc_busy    = 1'b0;
    mc_timeout = 1'b0;
    if (!rst) begin
      ForwardAE  = fwd_sel(RegWrite_M, Rd_M, RegWrite_W, Rd_W, RS1_E);
      ForwardBE  = fwd_sel(RegWrite_M, Rd_M, RegWrite_W, Rd_W, RS2_E);
      mc_busy    = busy;
      mc_timeout = timeout_q;
      if (PCSrc_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = hazard;
        StallD = hazard;
        FlushE = hazard;
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_events_q;
  logic [31:0] flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (StallD && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (FlushD && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_cycles_q;
  assign flush_events = rst ? 32'd0 : flush_events_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: each scenario task queues stimulus with its
// expected outputs, and expectations are popped and compared at the falling edge.
module tb_hazard_scoreboard;

  localparam int REG_AW     = 5;
  localparam int MC_TIMEOUT = 200;
  localparam int MC_CNT_W   = 8;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWrite_M, RegWrite_W, PCSrc_E;
  logic [REG_AW-1:0] Rd_M, Rd_W, Rd_E, RS1_E, RS2_E, RS1_D, RS2_D;
  logic [1:0]        ResultSrc_E;
  logic              mc_start_E, mc_op_D, mc_done;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushE, FlushD, mc_busy, mc_timeout;
  logic [31:0]       stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .MC_TIMEOUT(MC_TIMEOUT), .MC_CNT_W(MC_CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W), .Rd_E(Rd_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
    .ResultSrc_E(ResultSrc_E), .mc_start_E(mc_start_E), .mc_op_D(mc_op_D), .mc_done(mc_done),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic rst; logic rwM; logic rwW; logic pcsrc;
    logic [REG_AW-1:0] rdM, rdW, rdE, rs1E, rs2E, rs1D, rs2D;
    logic [1:0] resSrc;
    logic mcStart; logic mcOpD; logic mcDone;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa; logic [1:0] fb;
    logic sf; logic sd; logic fe; logic fd; logic busy; logic tmo;
    logic [31:0] sc; logic [31:0] fl;
  } obs_t;

  typedef struct packed { stim_t s; obs_t e; } vec_t;

  vec_t vecq[$];
  obs_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   perfStall = 0;
  int   perfFlush = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rstVec();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic obs_t ex(input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                              input logic sd, input logic fe, input logic fd,
                              input logic busy, input logic tmo);
    obs_t o;
    o = '0;
    o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.fe = fe; o.fd = fd;
    o.busy = busy; o.tmo = tmo;
    return o;
  endfunction

  function automatic obs_t exHaz(input logic stall, input logic busy, input logic tmo);
    return ex(2'b00, 2'b00, stall, stall, stall, 1'b0, busy, tmo);
  endfunction

  function automatic obs_t exBr(input logic busy, input logic tmo);
    return ex(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, busy, tmo);
  endfunction

  function automatic void addVec(input stim_t s, input obs_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecq.push_back(v);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.fa = ForwardAE; o.fb = ForwardBE; o.sf = StallF; o.sd = StallD;
    o.fe = FlushE; o.fd = FlushD; o.busy = mc_busy; o.tmo = mc_timeout;
    o.sc = stall_cycles; o.fl = flush_events;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; RegWrite_M = s.rwM; RegWrite_W = s.rwW; PCSrc_E = s.pcsrc;
    Rd_M = s.rdM; Rd_W = s.rdW; Rd_E = s.rdE; RS1_E = s.rs1E; RS2_E = s.rs2E;
    RS1_D = s.rs1D; RS2_D = s.rs2D; ResultSrc_E = s.resSrc;
    mc_start_E = s.mcStart; mc_op_D = s.mcOpD; mc_done = s.mcDone;
  endtask

  task automatic test_reset();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    s = rstVec();
    s.rwM = 1'b1; s.rdM = 5; s.rs1E = 5; s.pcsrc = 1'b1; s.mcStart = 1'b1;
    s.rdE = 3; s.rs1D = 3; s.resSrc = 2'b01; s.mcOpD = 1'b1;
    addVec(s, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec(s, ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    addVec(idle(), exHaz(0, 0, 0));
    s = idle(); s.mcOpD = 1'b1;
    addVec(s, exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  task automatic test_forwarding();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    int rwM[7]  = '{1, 1, 0, 1, 1, 1, 1};
    int rdM[7]  = '{5, 0, 5, 6, 6, 0, 7};
    int rwW[7]  = '{1, 1, 1, 1, 0, 1, 1};
    int rdW[7]  = '{5, 5, 5, 5, 5, 0, 7};
    int rs1E[7] = '{5, 5, 5, 5, 5, 0, 7};
    int rs2E[7] = '{0, 0, 5, 6, 6, 0, 7};
    int fa[7]   = '{2, 1, 1, 1, 0, 0, 2};
    int fb[7]   = '{0, 0, 1, 2, 2, 0, 2};
    for (int i = 0; i < 7; i++) begin
      s = idle();
      s.rwM = rwM[i][0]; s.rdM = REG_AW'(rdM[i]); s.rwW = rwW[i][0]; s.rdW = REG_AW'(rdW[i]);
      s.rs1E = REG_AW'(rs1E[i]); s.rs2E = REG_AW'(rs2E[i]);
      addVec(s, ex(2'(fa[i]), 2'(fb[i]), 0, 0, 0, 0, 0, 0));
    end
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL forwarding row %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  task automatic test_load_use();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    s = idle(); s.resSrc = 2'b01; s.rdE = 7; s.rs2D = 7; addVec(s, exHaz(1, 0, 0));
    addVec(idle(), exHaz(0, 0, 0));
    s = idle(); s.resSrc = 2'b01; s.rdE = 7; s.rs1D = 7; addVec(s, exHaz(1, 0, 0));
    s = idle(); s.resSrc = 2'b01; s.rdE = 0; s.rs2D = 0; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.resSrc = 2'b10; s.rdE = 7; s.rs2D = 7; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.resSrc = 2'b01; s.rdE = 7; s.rs1D = 3; s.rs2D = 4; addVec(s, exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL load_use cycle %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  task automatic test_multicycle_raw();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    int stallSeen = 0; int busySeen = 0;
    addVec(rstVec(), exHaz(0, 0, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 9; s.rs1D = 9; addVec(s, exHaz(1, 0, 0));
    for (int i = 1; i <= 11; i++) begin
      s = idle(); s.rs1D = 9; addVec(s, exHaz(1, 1, 0));
    end
    s = idle(); s.rs1D = 9; s.mcDone = 1'b1; addVec(s, exHaz(1, 1, 0));
    s = idle(); s.rs1D = 9; addVec(s, exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL multicycle_raw cycle %0d: got %h expected %h", n, got, want);
      end
      stallSeen += int'(StallD === 1'b1);
      busySeen  += int'(mc_busy === 1'b1);
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
    checks++;
    if (stallSeen != 13) begin
      errors++;
      $display("[TB] FAIL multicycle_raw stall_len: got %0d expected 13", stallSeen);
    end
    checks++;
    if (busySeen != 12) begin
      errors++;
      $display("[TB] FAIL multicycle_raw busy_len: got %0d expected 12", busySeen);
    end
    checks++;
    if (stall_cycles !== (PERF ? 32'd13 : 32'd0)) begin
      errors++;
      $display("[TB] FAIL multicycle_raw stall_cycles: got %0d expected %0d",
               stall_cycles, PERF ? 13 : 0);
    end
  endtask

  task automatic test_mc_ignore();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    addVec(rstVec(), exHaz(0, 0, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 4; s.rs1D = 1; s.mcOpD = 1'b1; addVec(s, exHaz(1, 0, 0));
    s = idle(); s.rs1D = 1; addVec(s, exHaz(0, 1, 0));
    s = idle(); s.rs2D = 4; addVec(s, exHaz(1, 1, 0));
    s = idle(); s.mcOpD = 1'b1; addVec(s, exHaz(1, 1, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 2; addVec(s, exHaz(0, 1, 0));
    s = idle(); s.mcDone = 1'b1; s.rs1D = 2; addVec(s, exHaz(0, 1, 0));
    s = idle(); s.mcDone = 1'b1; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.mcStart = 1'b1; s.mcDone = 1'b1; s.rdE = 0; addVec(s, exHaz(0, 0, 0));
    addVec(idle(), exHaz(0, 1, 0));
    s = idle(); s.mcDone = 1'b1; addVec(s, exHaz(0, 1, 0));
    addVec(idle(), exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL mc_ignore cycle %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  task automatic test_branch();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    addVec(rstVec(), exHaz(0, 0, 0));
    s = idle(); s.pcsrc = 1'b1; s.resSrc = 2'b01; s.rdE = 7; s.rs2D = 7; addVec(s, exBr(0, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 3; s.rs1D = 3; addVec(s, exHaz(1, 0, 0));
    s = idle(); s.pcsrc = 1'b1; s.rs1D = 3; addVec(s, exBr(1, 0));
    s = idle(); s.rs1D = 3; addVec(s, exHaz(1, 1, 0));
    s = idle(); s.rs1D = 3; s.mcDone = 1'b1; addVec(s, exHaz(1, 1, 0));
    addVec(idle(), exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL branch cycle %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  task automatic test_watchdog();
    stim_t s; vec_t v; obs_t got, want; int n = 0; int busySeen = 0;
    addVec(rstVec(), exHaz(0, 0, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 9; s.rs1D = 9; addVec(s, exHaz(1, 0, 0));
    for (int i = 1; i <= MC_TIMEOUT; i++) begin
      s = idle(); s.rs1D = 9; addVec(s, exHaz(1, 1, 0));
    end
    s = idle(); s.rs1D = 9; addVec(s, exHaz(0, 0, 1));
    s = idle(); s.mcDone = 1'b1; addVec(s, exHaz(0, 0, 1));
    s = idle(); s.mcStart = 1'b1; s.rdE = 9; s.rs1D = 9; addVec(s, exHaz(1, 0, 1));
    s = idle(); s.rs1D = 9; addVec(s, exHaz(1, 1, 1));
    s = idle(); s.rs1D = 9; s.mcDone = 1'b1; addVec(s, exHaz(1, 1, 1));
    addVec(idle(), exHaz(0, 0, 1));
    addVec(rstVec(), exHaz(0, 0, 0));
    addVec(idle(), exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL watchdog cycle %0d: got %h expected %h", n, got, want);
      end
      if (n <= MC_TIMEOUT + 2) busySeen += int'(mc_busy === 1'b1);
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
    checks++;
    if (busySeen != MC_TIMEOUT) begin
      errors++;
      $display("[TB] FAIL watchdog busy_len: got %0d expected %0d", busySeen, MC_TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_busy();
    stim_t s; vec_t v; obs_t got, want; int n = 0;
    addVec(rstVec(), exHaz(0, 0, 0));
    s = idle(); s.mcStart = 1'b1; s.rdE = 6; s.rs2D = 6; addVec(s, exHaz(1, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.rs2D = 6; addVec(s, exHaz(1, 1, 0));
    end
    s = rstVec(); s.rs2D = 6; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.mcDone = 1'b1; s.rs2D = 6; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.rs2D = 6; addVec(s, exHaz(0, 0, 0));
    s = idle(); s.mcOpD = 1'b1; addVec(s, exHaz(0, 0, 0));
    while (vecq.size() != 0) begin
      v = vecq.pop_front();
      @(posedge clk); #1;
      apply(v.s);
      want = v.e;
      want.sc = (PERF && !v.s.rst) ? 32'(perfStall) : 32'd0;
      want.fl = (PERF && !v.s.rst) ? 32'(perfFlush) : 32'd0;
      expq.push_back(want);
      @(negedge clk);
      got = sample();
      want = expq.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset_mid_busy cycle %0d: got %h expected %h", n, got, want);
      end
      perfStall = v.s.rst ? 0 : perfStall + int'(want.sd);
      perfFlush = v.s.rst ? 0 : perfFlush + int'(want.fd);
      n++;
    end
  endtask

  initial begin
    apply(rstVec());
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle_raw();
    test_mc_ignore();
    test_branch();
    test_watchdog();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete within the time limit");
    $fatal(1, "[TB] time limit expired");
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MC_TIMEOUT, default 200, maximum BUSY cycles before watchdog trips.
REQ-003 SHALL have parameter MC_CNT_W, default 8, width of the BUSY cycle counter; MC_TIMEOUT < 2**MC_CNT_W.
REQ-004 SHALL have ports (name, direction, width, meaning), in this order:
- clk in 1: the single clock.
- rst in 1: reset; synchronous, active-high.
- RegWrite_M, RegWrite_W in 1: M-stage and W-stage write enables.
- PCSrc_E in 1: taken branch or jump resolved in E.
- Rd_M, Rd_W, Rd_E in REG_AW: destination registers.
- RS1_E, RS2_E, RS1_D, RS2_D in REG_AW: source registers.
- ResultSrc_E in 2: value 2'b01 marks a load in E.
- mc_start_E in 1: multicycle op (MUL/DIV) launches from E this cycle.
- mc_op_D in 1: D-stage instruction is a multicycle op.
- mc_done in 1: multicycle unit writes its result to the regfile this cycle.
- ForwardAE, ForwardBE out 2: operand forward selects.
- StallF, StallD, FlushE, FlushD out 1: pipeline controls.
- mc_busy out 1: FSM is in BUSY.
- mc_timeout out 1: sticky watchdog error.
- stall_cycles, flush_events out 32: performance counters.

Function
REQ-005 ForwardAE SHALL be 2'b10 if RegWrite_M, Rd_M != 0 and Rd_M == RS1_E; else 2'b01 if RegWrite_W, Rd_W != 0 and Rd_W == RS1_E; else 2'b00. ForwardBE SHALL follow the same rule on RS2_E.
REQ-006 lwStall SHALL be ResultSrc_E == 2'b01, Rd_E != 0, and (RS1_D == Rd_E or RS2_D == Rd_E).
REQ-007 The FSM SHALL have states IDLE and BUSY; IDLE->BUSY on mc_start_E; BUSY->IDLE on mc_done or on watchdog trip.
REQ-008 On the IDLE->BUSY transition, the block SHALL capture Rd_E into pend_rd and clear the BUSY cycle counter.
REQ-009 mcStall SHALL be asserted for any of:
- mc_start_E, Rd_E != 0, and Rd_E matches RS1_D or RS2_D;
- BUSY, pend_rd != 0, and pend_rd matches RS1_D or RS2_D;
- (BUSY or mc_start_E) and mc_op_D.
REQ-010 mcStall SHALL remain asserted through the mc_done cycle and deassert the following cycle.
REQ-011 With PCSrc_E = 0: StallF = StallD = FlushE = lwStall | mcStall, and FlushD = 0.
REQ-012 With PCSrc_E = 1: StallF = StallD = 0 and FlushD = FlushE = 1; the branch overrides every stall.
REQ-013 The block SHALL ignore mc_done in IDLE, mc_done coincident with IDLE mc_start_E, and mc_start_E in BUSY.
REQ-014 The BUSY counter SHALL increment every BUSY cycle; when it reaches MC_TIMEOUT without mc_done, the FSM SHALL go to IDLE and set mc_timeout.
REQ-015 mc_timeout SHALL stay set until rst; the watchdog trip SHALL release mcStall on the next cycle.
REQ-016 mc_busy SHALL be asserted exactly while the state is BUSY.

Reset
REQ-017 While rst = 1, every output SHALL be combinationally 0, including forwards, stalls and flushes.
REQ-018 On a clock edge with rst = 1: state -> IDLE, pend_rd -> 0, BUSY counter -> 0, mc_timeout -> 0, perf counters -> 0.
REQ-019 Reset asserted mid-BUSY SHALL abandon the pending op; a later mc_done SHALL be ignored.

Configuration
REQ-020 With macro HAZARD_SCOREBOARD_PERF_EN defined:
- stall_cycles SHALL increment on every cycle StallD = 1;
- flush_events SHALL increment on every cycle FlushD = 1;
- both SHALL saturate at 32'hFFFFFFFF.
REQ-021 With HAZARD_SCOREBOARD_PERF_EN undefined, stall_cycles and flush_events SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-022 Forwarding: RegWrite_M = 1, Rd_M = 5, RegWrite_W = 1, Rd_W = 5, RS1_E = 5 -> ForwardAE = 10. Same stimulus with Rd_M = 0 -> ForwardAE = 01.
REQ-023 Load-use: ResultSrc_E = 01, Rd_E = 7, RS2_D = 7 -> StallF = StallD = FlushE = 1 for one cycle. Same stimulus with Rd_E = 0 -> all 0.
REQ-024 Multicycle RAW: mc_start_E with Rd_E = 9, D reads x9, mc_done 12 cycles later -> stalls high 13 cycles, mc_busy high 12 cycles, stall_cycles = 13 (PERF_EN defined).
REQ-025 Branch priority: BUSY, pend_rd = 3, RS1_D = 3, PCSrc_E = 1 -> StallD = 0, FlushD = 1, FlushE = 1.
REQ-026 Watchdog: MC_TIMEOUT = 200, mc_start_E, no mc_done -> mc_timeout = 1 after 200 BUSY cycles; stall released next cycle; mc_timeout cleared only by rst.
REQ-027 Reset mid-BUSY: rst for 1 cycle, then mc_done pulsed -> mc_busy = 0, no stall, mc_timeout = 0.
